// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter and its round-robin picker.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int MEM_LAT_DEFAULT = 1;

    // Index width for n masters; a single master still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping around.
module rr_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx,
    output logic            pick_valid
);

    // Two copies of req turn the wrap-around search into a straight upward scan.
    logic [2*NREQ-1:0] req_dbl;

    assign req_dbl = {req, req};

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves a latch behind.
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_valid && req_dbl[int'(last_grant) + i]) begin
                pick_valid = 1'b1;
                if (int'(last_grant) + i >= NREQ) begin
                    pick_idx = IW'(int'(last_grant) + i - NREQ);
                    pick[int'(last_grant) + i - NREQ] = 1'b1;
                end else begin
                    pick_idx = IW'(int'(last_grant) + i);
                    pick[int'(last_grant) + i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NREQ masters; one transaction at a time,
// strobes held MEM_LAT cycles, then a one-cycle ack to the owner. All outputs are registered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               read,
    output logic               write,
    output logic [AW-1:0]      address,
    output logic [DW-1:0]      mem_out,
    input  logic [DW-1:0]      mem_in
);

    localparam int            IW       = idx_width(NREQ);
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_l_q, we_l_d;
    logic [NREQ-1:0] ack_d, grant_d;
    logic [DW-1:0]   rdata_d, mem_out_d;
    logic [AW-1:0]   address_d;
    logic            busy_d, read_d, write_d;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .req       (req),
        .last_grant(last_grant_q),
        .pick      (pick),
        .pick_idx  (pick_idx),
        .pick_valid(pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_l_d       = we_l_q;
        ack_d        = '0;
        grant_d      = grant;
        rdata_d      = rdata;
        address_d    = address;
        mem_out_d    = mem_out;
        busy_d       = busy;
        read_d       = read;
        write_d      = write;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    // The winner's request is latched here; later changes on its inputs are ignored.
                    grant_d      = pick;
                    last_grant_d = pick_idx;
                    we_l_d       = we[pick_idx];
                    address_d    = addr[pick_idx*AW +: AW];
                    mem_out_d    = wdata[pick_idx*DW +: DW];
                    read_d       = ~we[pick_idx];
                    write_d      = we[pick_idx];
                    busy_d       = 1'b1;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!we_l_q) begin
                        rdata_d = mem_in;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ack_d   = grant;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            cnt_q        <= '0;
            we_l_q       <= 1'b0;
            ack          <= '0;
            grant        <= '0;
            rdata        <= '0;
            address      <= '0;
            mem_out      <= '0;
            busy         <= 1'b0;
            read         <= 1'b0;
            write        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_l_q       <= we_l_d;
            ack          <= ack_d;
            grant        <= grant_d;
            rdata        <= rdata_d;
            address      <= address_d;
            mem_out      <= mem_out_d;
            busy         <= busy_d;
            read         <= read_d;
            write        <= write_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand sequences, and randomized masters
// checked against a transaction-schedule model; instances with MEM_LAT=2 and MEM_LAT=1.
module tb_mem_bus_arbiter;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [1:0]  grant;
        logic [1:0]  ack;
        logic        rd;
        logic        wr;
        logic        busy;
        logic [15:0] adr;
        logic [15:0] rdat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;

    logic [1:0]  ack2, grant2, ack1, grant1;
    logic [15:0] rdata2, address2, mem_out2, mem_in2;
    logic [15:0] rdata1, address1, mem_out1, mem_in1;
    logic        busy2, read2, write2, busy1, read1, write1;

    logic [1:0]  obs_ack, obs_grant;
    logic [15:0] obs_rdata, obs_address, obs_mem_out;
    logic        obs_busy, obs_read, obs_write;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
    endfunction

    assign mem_in2 = mem_fn(address2);
    assign mem_in1 = mem_fn(address1);

    assign obs_ack     = sel ? ack1     : ack2;
    assign obs_grant   = sel ? grant1   : grant2;
    assign obs_rdata   = sel ? rdata1   : rdata2;
    assign obs_address = sel ? address1 : address2;
    assign obs_mem_out = sel ? mem_out1 : mem_out2;
    assign obs_busy    = sel ? busy1    : busy2;
    assign obs_read    = sel ? read1    : read2;
    assign obs_write   = sel ? write1   : write2;

    mem_bus_arbiter #(.NREQ(2), .AW(16), .DW(16), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst_b(rst_b), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack2), .rdata(rdata2), .grant(grant2), .busy(busy2), .read(read2),
        .write(write2), .address(address2), .mem_out(mem_out2), .mem_in(mem_in2)
    );

    mem_bus_arbiter #(.NREQ(2), .AW(16), .DW(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .grant(grant1), .busy(busy1), .read(read1),
        .write(write1), .address(address1), .mem_out(mem_out1), .mem_in(mem_in1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [1:0] g,
                                input logic [1:0] a, input logic rd, input logic wr,
                                input logic bz, input logic [15:0] ad, input logic [15:0] rt);
        vec_t v;
        v.req = r; v.we = w; v.grant = g; v.ack = a; v.rd = rd; v.wr = wr;
        v.busy = bz; v.adr = ad; v.rdat = rt;
        return v;
    endfunction

    task automatic rand_payload(input int i);
        we[i]              = 1'($urandom_range(1, 0));
        addr[i*16 +: 16]   = 16'($urandom);
        wdata[i*16 +: 16]  = 16'($urandom);
    endtask

    // Masters obey the handshake; the model schedules each transaction from its start edge.
    task automatic run_random(input int lat, input int ncyc);
        int          n, cur_s, cur_m, last, d;
        bit          found;
        logic        cur_we;
        logic [15:0] cur_addr, cur_wdata, exp_rdata;
        logic [1:0]  owned, e_grant, e_ack;
        logic        e_rd, e_wr, e_busy;
        sel   = (lat == 1);
        rst_b = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        @(negedge clk);
        rst_b = 1'b1;
        n = 0; cur_s = -100; cur_m = 0; last = 1; cur_we = 1'b0;
        cur_addr = '0; cur_wdata = '0; exp_rdata = '0; owned = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (obs_ack[i]) begin
                    owned[i] = 1'b0;
                    if ($urandom_range(1, 0) == 1) begin
                        req[i] = 1'b1;
                        owned[i] = 1'b1;
                        rand_payload(i);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (owned[i] && obs_grant[i]) begin
                    if ($urandom_range(3, 0) == 0) rand_payload(i);
                    if ($urandom_range(7, 0) == 0) req[i] = 1'b0;
                end else if (!owned[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    owned[i] = 1'b1;
                    rand_payload(i);
                end
            end

            n++;
            if (n > cur_s + lat + 1 && req != 2'b00) begin
                found = 1'b0;
                for (int k = 1; k <= 2; k++) begin
                    if (!found && req[(last + k) % 2]) begin
                        found = 1'b1;
                        cur_m = (last + k) % 2;
                    end
                end
                cur_s     = n;
                last      = cur_m;
                cur_we    = we[cur_m];
                cur_addr  = addr[cur_m*16 +: 16];
                cur_wdata = wdata[cur_m*16 +: 16];
            end
            d = n - cur_s;
            if (d == lat && !cur_we) exp_rdata = mem_fn(cur_addr);
            e_busy  = (d >= 0 && d <= lat);
            e_grant = e_busy ? 2'(1 << cur_m) : 2'b00;
            e_ack   = (d == lat) ? e_grant : 2'b00;
            e_rd    = (d >= 0 && d < lat && !cur_we);
            e_wr    = (d >= 0 && d < lat && cur_we);

            @(negedge clk);
            check($sformatf("rnd%0d_c%0d_grant", lat, c), 32'(obs_grant), 32'(e_grant));
            check($sformatf("rnd%0d_c%0d_ack", lat, c), 32'(obs_ack), 32'(e_ack));
            check($sformatf("rnd%0d_c%0d_busy", lat, c), 32'(obs_busy), 32'(e_busy));
            check($sformatf("rnd%0d_c%0d_read", lat, c), 32'(obs_read), 32'(e_rd));
            check($sformatf("rnd%0d_c%0d_write", lat, c), 32'(obs_write), 32'(e_wr));
            check($sformatf("rnd%0d_c%0d_rdata", lat, c), 32'(obs_rdata), 32'(exp_rdata));
            if (e_rd || e_wr)
                check($sformatf("rnd%0d_c%0d_address", lat, c), 32'(obs_address), 32'(cur_addr));
            if (e_wr)
                check($sformatf("rnd%0d_c%0d_mem_out", lat, c), 32'(obs_mem_out), 32'(cur_wdata));
        end
    endtask

    initial begin
        logic [1:0]  g;
        logic [15:0] a, r;
        int          acks;

        // Directed table for MEM_LAT=2: single read, single write, then four contended reads.
        vecs.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 1, 16'h0040, 16'h0000));
        vecs.push_back(mk(2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 1, 16'h0040, 16'h0000));
        vecs.push_back(mk(2'b01, 2'b00, 2'b01, 2'b01, 0, 0, 1, 16'h0040, 16'hBEEF));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 16'h0000, 16'hBEEF));
        vecs.push_back(mk(2'b10, 2'b10, 2'b10, 2'b00, 0, 1, 1, 16'h0200, 16'hBEEF));
        vecs.push_back(mk(2'b10, 2'b10, 2'b10, 2'b00, 0, 1, 1, 16'h0200, 16'hBEEF));
        vecs.push_back(mk(2'b10, 2'b10, 2'b10, 2'b10, 0, 0, 1, 16'h0200, 16'hBEEF));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 16'h0000, 16'hBEEF));
        r = 16'hBEEF;
        for (int j = 0; j < 4; j++) begin
            g = (j % 2 == 1) ? 2'b10 : 2'b01;
            a = (j % 2 == 1) ? 16'h0200 : 16'h0040;
            vecs.push_back(mk(2'b11, 2'b00, g, 2'b00, 1, 0, 1, a, r));
            vecs.push_back(mk(2'b11, 2'b00, g, 2'b00, 1, 0, 1, a, r));
            r = mem_fn(a);
            vecs.push_back(mk(2'b11, 2'b00, g, g, 0, 0, 1, a, r));
            vecs.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 16'h0000, r));
        end

        sel   = 1'b0;
        addr  = {16'h0200, 16'h0040};
        wdata = {16'h1234, 16'h0000};
        we    = 2'b00;

        // Reset held with both masters requesting.
        req   = 2'b11;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(grant2), 32'h0);
        check("reset_read", 32'(read2), 32'h0);
        check("reset_write", 32'(write2), 32'h0);
        check("reset_ack", 32'(ack2), 32'h0);
        check("reset_busy", 32'(busy2), 32'h0);
        check("reset_rdata", 32'(rdata2), 32'h0);
        check("reset_address", 32'(address2), 32'h0);
        check("reset_mem_out", 32'(mem_out2), 32'h0);
        rst_b = 1'b1;
        @(negedge clk);
        check("first_grant_m0", 32'(grant2), 32'h1);
        rst_b = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        rst_b = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            req = vecs[k].req;
            we  = vecs[k].we;
            @(negedge clk);
            check($sformatf("vec%0d_grant", k), 32'(grant2), 32'(vecs[k].grant));
            check($sformatf("vec%0d_ack", k), 32'(ack2), 32'(vecs[k].ack));
            check($sformatf("vec%0d_read", k), 32'(read2), 32'(vecs[k].rd));
            check($sformatf("vec%0d_write", k), 32'(write2), 32'(vecs[k].wr));
            check($sformatf("vec%0d_busy", k), 32'(busy2), 32'(vecs[k].busy));
            check($sformatf("vec%0d_rdata", k), 32'(rdata2), 32'(vecs[k].rdat));
            if (vecs[k].rd || vecs[k].wr)
                check($sformatf("vec%0d_address", k), 32'(address2), 32'(vecs[k].adr));
            if (vecs[k].wr)
                check($sformatf("vec%0d_mem_out", k), 32'(mem_out2), 32'h1234);
        end

        // Async reset in the first strobe cycle aborts the read.
        req = 2'b00;
        @(negedge clk);
        req = 2'b01;
        we  = 2'b00;
        @(negedge clk);
        check("abort_pre_read", 32'(read2), 32'h1);
        #1 rst_b = 1'b0;
        #1;
        check("abort_read_drop", 32'(read2), 32'h0);
        check("abort_write_drop", 32'(write2), 32'h0);
        check("abort_grant_drop", 32'(grant2), 32'h0);
        check("abort_busy_drop", 32'(busy2), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        req   = 2'b00;
        acks  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack2 != 2'b00) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'h0);
        check("abort_idle_busy", 32'(busy2), 32'h0);
        check("abort_idle_grant", 32'(grant2), 32'h0);

        // MEM_LAT=1 instance: master 0 drops req during ACCESS.
        sel = 1'b1;
        req = 2'b01;
        we  = 2'b00;
        @(negedge clk);
        check("lat1_grant", 32'(grant1), 32'h1);
        check("lat1_read", 32'(read1), 32'h1);
        req = 2'b00;
        @(negedge clk);
        check("lat1_ack", 32'(ack1), 32'h1);
        check("lat1_rdata", 32'(rdata1), 32'hBEEF);
        check("lat1_read_low", 32'(read1), 32'h0);
        @(negedge clk);
        check("lat1_idle_grant", 32'(grant1), 32'h0);
        check("lat1_idle_busy", 32'(busy1), 32'h0);
        check("lat1_idle_ack", 32'(ack1), 32'h0);

        run_random(2, 400);
        run_random(1, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
